// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// The master side is the environment (fetch plus consumer); the slave side is the stage.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func1;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, opcode, func3, func1,
               fmt, imm, rd_we, illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, opcode, func3, func1,
               fmt, imm, rd_we, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready handshakes, optional skid entry and flush.
// Define DECODE_ILLEGAL_EN to build the illegal-instruction check.
module decode_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32,
    parameter int unsigned SKID = 1
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_X = 3'd7;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic            func1;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    // EMPTY: nothing held; ONE: main holds a beat; TWO: main and skid both hold
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

    state_e      state_q, state_d;
    entry_t      main_q, main_d;
    entry_t      skid_q, skid_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;
    entry_t      dec;
    logic [31:0] instr;
    logic [31:0] imm32;
    logic        in_ready_c;
    logic        in_fire;

    // Decode the incoming word so the result can be registered on acceptance
    always_comb begin
        instr       = bus.in_instr;
        dec         = '0;
        imm32       = '0;
        dec.pc      = bus.in_pc;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = instr[11:7];
        dec.opcode  = instr[6:0];
        dec.func3   = instr[14:12];
        dec.func1   = instr[30];

        case (instr[6:0])
            7'b0110011:                         dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:             dec.fmt = FMT_I;
            7'b0100011:                         dec.fmt = FMT_S;
            7'b1100011:                         dec.fmt = FMT_B;
            7'b0110111, 7'b0010111:             dec.fmt = FMT_U;
            7'b1101111:                         dec.fmt = FMT_J;
            7'b0011011:                         dec.fmt = (XLEN == 64) ? FMT_I : FMT_X;
            7'b0111011:                         dec.fmt = (XLEN == 64) ? FMT_R : FMT_X;
            default:                            dec.fmt = FMT_X;
        endcase

        case (dec.fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        dec.imm   = XLEN'($signed(imm32));
        dec.rd_we = ((dec.fmt == FMT_R) || (dec.fmt == FMT_I) ||
                     (dec.fmt == FMT_U) || (dec.fmt == FMT_J)) && (dec.rd != 5'd0);

`ifdef DECODE_ILLEGAL_EN
        dec.illegal = (instr[1:0] != 2'b11) || (dec.fmt == FMT_X) ||
                      ((instr[6:0] == 7'b0110011) && (instr[31:25] != 7'b0000000) &&
                       (instr[31:25] != 7'b0100000));
        if (dec.illegal) begin
            dec.rd_we = 1'b0;
            dec.imm   = '0;
        end
`else
        dec.illegal = 1'b0;
`endif
    end

    // Without a skid entry the stage can only accept when main is free or draining
    assign in_ready_c = (SKID != 0) ? ready_q
                                    : (ready_q && (!valid_q || bus.out_ready));

    // Occupancy FSM: main/skid movement, flush drops everything including this beat
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        in_fire = bus.in_valid && in_ready_c && !bus.flush;

        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && bus.out_ready) begin
                        main_d = dec;
                    end else if (in_fire) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end else if (bus.out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (bus.out_ready) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        valid_d = (state_d != ST_EMPTY);
        ready_d = (SKID != 0) ? (state_d != ST_TWO) : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.rd        = main_q.rd;
    assign bus.opcode    = main_q.opcode;
    assign bus.func3     = main_q.func3;
    assign bus.func1     = main_q.func1;
    assign bus.fmt       = main_q.fmt;
    assign bus.imm       = main_q.imm;
    assign bus.rd_we     = main_q.rd_we;
    assign bus.illegal   = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32, PC_W=32, SKID=1).
module tb_decode_stage;
    localparam int unsigned XLEN = 32;
    localparam int unsigned PC_W = 32;
`ifdef DECODE_ILLEGAL_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_asrt = 0;
    int   n_fail = 0;

    decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .SKID(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    // Present one beat with out_ready=1 and check the decoded result a cycle later
    task automatic vec(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [2:0] fmt, input logic [31:0] imm,
                       input logic rd_we, input logic ill);
        drive(instr, pc);
        step();
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".pc"},    64'(bus.out_pc),    64'(pc));
        chk({tag, ".fmt"},   64'(bus.fmt),       64'(fmt));
        chk({tag, ".imm"},   64'(bus.imm),       64'(imm));
        chk({tag, ".rd_we"}, 64'(bus.rd_we),     64'(rd_we));
        chk({tag, ".ill"},   64'(bus.illegal),   64'(ill));
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.imm",       64'(bus.imm),       64'd0);
        chk("rst.rd",        64'(bus.rd),        64'd0);
        chk("rst.pc",        64'(bus.out_pc),    64'd0);
        rst = 1'b0;
        step();
        chk("post_rst.in_ready",  64'(bus.in_ready),  64'd1);
        chk("post_rst.out_valid", 64'(bus.out_valid), 64'd0);

        // Back-to-back decode vectors at full throughput
        vec("addi", 32'hFFF10093, 32'h100, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("addi.rs1",    64'(bus.rs1),    64'd2);
        chk("addi.rd",     64'(bus.rd),     64'd1);
        chk("addi.rs2",    64'(bus.rs2),    64'd31);
        chk("addi.opcode", 64'(bus.opcode), 64'h13);
        chk("addi.func1",  64'(bus.func1),  64'd1);
        vec("sw",   32'h00112223, 32'h104, 3'd2, 32'h4, 1'b0, 1'b0);
        chk("sw.rs1",   64'(bus.rs1),   64'd2);
        chk("sw.rs2",   64'(bus.rs2),   64'd1);
        chk("sw.func3", 64'(bus.func3), 64'd2);
        vec("beq",  32'hFE000EE3, 32'h108, 3'd3, 32'hFFFFFFFC, 1'b0, 1'b0);
        vec("lui",  32'h123452B7, 32'h10C, 3'd4, 32'h12345000, 1'b1, 1'b0);
        chk("lui.rd", 64'(bus.rd), 64'd5);
        vec("add",  32'h002081B3, 32'h110, 3'd0, 32'h0, 1'b1, 1'b0);
        chk("add.rs2", 64'(bus.rs2), 64'd2);
        vec("sub",  32'h402081B3, 32'h114, 3'd0, 32'h0, 1'b1, 1'b0);
        chk("sub.func1", 64'(bus.func1), 64'd1);
        vec("jal",  32'h0080006F, 32'h118, 3'd5, 32'h8, 1'b0, 1'b0);
        vec("lw",   32'h7FF02283, 32'h11C, 3'd1, 32'h7FF, 1'b1, 1'b0);
        vec("addiw32", 32'h0000009B, 32'h120, 3'd7, 32'h0, 1'b0, ILL);
        vec("op7f", 32'h000000FF, 32'h124, 3'd7, 32'h0, 1'b0, ILL);
        vec("zero", 32'h00000000, 32'h128, 3'd7, 32'h0, 1'b0, ILL);
        vec("mul",  32'h022081B3, 32'h12C, 3'd0, 32'h0, !ILL, ILL);
        vec("nop",  32'h00000013, 32'h130, 3'd1, 32'h0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        chk("idle.out_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure: A held, B in skid, C stalled, then drained in order
        bus.out_ready = 1'b0;
        drive(32'h00000093, 32'h200);
        step();
        chk("bp.a_valid", 64'(bus.out_valid), 64'd1);
        chk("bp.a_pc",    64'(bus.out_pc),    64'h200);
        chk("bp.a_rdy",   64'(bus.in_ready),  64'd1);
        drive(32'h00000113, 32'h204);
        step();
        chk("bp.hold_pc", 64'(bus.out_pc),   64'h200);
        chk("bp.hold_rd", 64'(bus.rd),       64'd1);
        chk("bp.full",    64'(bus.in_ready), 64'd0);
        drive(32'h00000193, 32'h208);
        step();
        chk("bp.stall_pc",  64'(bus.out_pc),   64'h200);
        chk("bp.stall_rdy", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("bp.b_pc",  64'(bus.out_pc),   64'h204);
        chk("bp.b_rd",  64'(bus.rd),       64'd2);
        chk("bp.b_rdy", 64'(bus.in_ready), 64'd1);
        step();
        chk("bp.c_pc",    64'(bus.out_pc),    64'h208);
        chk("bp.c_rd",    64'(bus.rd),        64'd3);
        chk("bp.c_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        step();
        chk("bp.drained", 64'(bus.out_valid), 64'd0);

        // Flush with both entries held and a beat presented
        bus.out_ready = 1'b0;
        drive(32'h00000213, 32'h300);
        step();
        drive(32'h00000293, 32'h304);
        step();
        chk("fl.full_rdy", 64'(bus.in_ready), 64'd0);
        chk("fl.full_pc",  64'(bus.out_pc),   64'h300);
        bus.flush = 1'b1;
        drive(32'h00000313, 32'h308);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl.valid", 64'(bus.out_valid), 64'd0);
        chk("fl.rdy",   64'(bus.in_ready),  64'd1);
        step();
        chk("fl.stays_empty", 64'(bus.out_valid), 64'd0);

        // Flush drops the beat even though in_ready is high
        drive(32'h00000393, 32'h30C);
        step();
        chk("fl2.g_valid", 64'(bus.out_valid), 64'd1);
        chk("fl2.g_rdy",   64'(bus.in_ready),  64'd1);
        bus.flush = 1'b1;
        drive(32'h00000413, 32'h310);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl2.valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("fl2.no_ghost", 64'(bus.out_valid), 64'd0);
        drive(32'h00000493, 32'h314);
        step();
        chk("fl2.i_pc", 64'(bus.out_pc), 64'h314);
        chk("fl2.i_rd", 64'(bus.rd),     64'd9);
        bus.in_valid = 1'b0;

        // Asynchronous reset clears a held beat without waiting for a clock
        bus.out_ready = 1'b0;
        drive(32'hFFF10093, 32'h400);
        step();
        bus.in_valid = 1'b0;
        chk("mr.loaded", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr.valid", 64'(bus.out_valid), 64'd0);
        chk("mr.imm",   64'(bus.imm),       64'd0);
        chk("mr.pc",    64'(bus.out_pc),    64'd0);
        chk("mr.rdy",   64'(bus.in_ready),  64'd0);
        step();
        rst = 1'b0;
        step();
        chk("mr.rdy_back", 64'(bus.in_ready),  64'd1);
        chk("mr.empty",    64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
